// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and write-request type
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting one past the last winner
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  // scan from farthest to nearest offset so the nearest requester after the pointer wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port plus busy scoreboard
module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_reg,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    reg_write,
  output logic [ADDR_W-1:0]       write_register,
  output logic [DATA_W-1:0]       write_data,
  input  logic                    reserve_valid,
  input  logic [ADDR_W-1:0]       reserve_reg,
  input  logic [ADDR_W-1:0]       query_reg_1,
  input  logic [ADDR_W-1:0]       query_reg_2,
  output logic                    busy_1,
  output logic                    busy_2,
  output logic [2**ADDR_W-1:0]    busy_vec
);
  localparam int IW = $clog2(N_REQ);
  localparam int NR = 2**ADDR_W;
  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     idx, last_q, last_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NR-1:0]     busy_q, busy_d;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i(req_valid),
    .ptr_i(last_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  assign req_ready      = rst_n ? gnt : '0;
  assign reg_write      = wen_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign busy_vec       = busy_q;
  assign busy_1         = busy_q[query_reg_1];
  assign busy_2         = busy_q[query_reg_2];
  // next pointer, registered write port and scoreboard; a same-edge reserve beats the clear
  always_comb begin
    last_d  = |gnt ? idx : last_q;
    wen_d   = |gnt;
    wreg_d  = |gnt ? req_reg[idx*ADDR_W +: ADDR_W] : wreg_q;
    wdata_d = |gnt ? req_data[idx*DATA_W +: DATA_W] : wdata_q;
    busy_d  = '0;
    for (int r = 0; r < NR; r++)
      busy_d[r] = (reserve_valid && reserve_reg == ADDR_W'(r)) ||
                  (busy_q[r] && !(wen_q && wreg_q == ADDR_W'(r)));
  end
  // state flops; reset drops any write in flight and hands first priority to requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= IW'(N_REQ-1);
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a write scoreboard and negedge register-file model
module tb_regfile_write_arbiter;
  localparam int N = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0] req_ready;
  logic reg_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic reserve_valid;
  logic [AW-1:0] reserve_reg, query_reg_1, query_reg_2;
  logic busy_1, busy_2;
  logic [31:0] busy_vec;
  logic [AW-1:0] rr [N];
  logic [DW-1:0] dd [N];
  logic [DW-1:0] rf [32];
  exp_t sb [$];
  int tests = 0;
  int fails = 0;
  regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .query_reg_1(query_reg_1), .query_reg_2(query_reg_2), .busy_1(busy_1), .busy_2(busy_2),
    .busy_vec(busy_vec)
  );
  always #5 clk = ~clk;
  always_comb begin
    req_reg  = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_reg[i*AW +: AW]  = rr[i];
      req_data[i*DW +: DW] = dd[i];
    end
  end
  always @(negedge clk) if (reg_write) rf[write_register] <= write_data;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] g);
    exp_t e;
    req_valid = v;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(g));
    for (int i = 0; i < N; i++)
      if (g[i]) begin
        e.r = rr[i];
        e.d = dd[i];
        sb.push_back(e);
      end
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && reg_write) begin
        if (sb.size() == 0) check("spurious reg_write", 64'(reg_write), 64'(0));
        else begin
          e = sb.pop_front();
          check("write_register", 64'(write_register), 64'(e.r));
          check("write_data", 64'(write_data), 64'(e.d));
        end
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      rr[i] = AW'(10 + i);
      dd[i] = 32'hA000_0000 + DW'(i);
    end
    rst_n = 1'b0;
    req_valid = '1;
    reserve_valid = 1'b0;
    reserve_reg = '0;
    query_reg_1 = '0;
    query_reg_2 = '0;
    @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset reg_write", 64'(reg_write), 64'(0));
    check("reset busy_vec", 64'(busy_vec), 64'(0));
    check("reset write_register", 64'(write_register), 64'(0));
    check("reset write_data", 64'(write_data), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b101, 3'b001);
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    for (int c = 0; c < 4; c++) begin
      step(3'b000, 3'b000);
      check("idle reg_write", 64'(reg_write), 64'(0));
      check("idle write_register", 64'(write_register), 64'(rr[0]));
      check("idle write_data", 64'(write_data), 64'(dd[0]));
    end
    step(3'b111, 3'b010);
    rr[1] = 5;
    dd[1] = 32'hDEAD_BEEF;
    step(3'b010, 3'b010);
    check("single reg_write", 64'(reg_write), 64'(1));
    check("single write_register", 64'(write_register), 64'(5));
    step(3'b000, 3'b000);
    check("regfile r5", 64'(rf[5]), 64'(32'hDEAD_BEEF));
    check("non-busy write stays clear", 64'(busy_vec[5]), 64'(0));
    for (int c = 0; c < 3; c++) begin
      dd[1] = 32'hB0B0_0000 + DW'(c);
      step(3'b010, 3'b010);
    end
    step(3'b000, 3'b000);
    reserve_valid = 1'b1;
    reserve_reg = 7;
    query_reg_1 = 7;
    #1 check("busy_1 before reserve", 64'(busy_1), 64'(0));
    @(posedge clk);
    #1 reserve_valid = 1'b0;
    check("busy_1 after reserve", 64'(busy_1), 64'(1));
    reserve_valid = 1'b1;
    reserve_reg = 0;
    query_reg_2 = 0;
    @(posedge clk);
    #1 reserve_valid = 1'b0;
    check("busy_2 reg0 reserved", 64'(busy_2), 64'(1));
    rr[0] = 7;
    dd[0] = 32'h7777_0007;
    step(3'b001, 3'b001);
    check("busy_1 cycle t+1", 64'(busy_1), 64'(1));
    step(3'b000, 3'b000);
    check("busy_1 cycle t+2", 64'(busy_1), 64'(0));
    check("regfile r7", 64'(rf[7]), 64'(32'h7777_0007));
    rr[2] = 9;
    dd[2] = 32'h9999_0009;
    step(3'b100, 3'b100);
    reserve_valid = 1'b1;
    reserve_reg = 9;
    step(3'b000, 3'b000);
    reserve_valid = 1'b0;
    check("collision busy9", 64'(busy_vec[9]), 64'(1));
    step(3'b000, 3'b000);
    check("busy_vec before reset", 64'(busy_vec), 64'(32'h0000_0201));
    rr[0] = 20;
    dd[0] = 32'hC000_0000;
    rr[1] = 21;
    dd[1] = 32'hC000_0001;
    step(3'b111, 3'b001);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset reg_write", 64'(reg_write), 64'(0));
    check("midreset req_ready", 64'(req_ready), 64'(0));
    check("midreset busy_vec", 64'(busy_vec), 64'(0));
    check("midreset write_register", 64'(write_register), 64'(0));
    check("midreset write_data", 64'(write_data), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
